mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between the IF stage (instruction read)
//  and the MEM stage (data read/write). Each grant holds the memory for a
//  fixed wait-state access. Emits per-requester stall signals that feed the
//  pipeline freeze logic. Sits between the IF/MEM stages and the memory.
// PARAMETERS
//  ADDR_W       32  address width, both requesters and memory side
//  DATA_W       32  data width
//  WAIT_CYCLES  2   extra cycles the memory needs; access lasts WAIT_CYCLES+1 cycles (valid 0..15)
//  STARVE_LIMIT 4   consecutive data grants while IF waits before IF is forced first (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active low
//  if_req     in   1       instruction fetch request, held until if_ready
//  if_addr    in   ADDR_W  fetch address
//  if_ready   out  1       fetch completes this cycle
//  if_rdata   out  DATA_W  fetched word, valid while if_ready
//  dm_req     in   1       data request, held until dm_ready
//  dm_we      in   1       1 = write, 0 = read
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  write data
//  dm_ready   out  1       data access completes this cycle
//  dm_rdata   out  DATA_W  read word, valid while dm_ready and !dm_we
//  mem_cs     out  1       memory select, registered
//  mem_we     out  1       memory write enable, registered
//  mem_addr   out  ADDR_W  memory address, registered
//  mem_wdata  out  DATA_W  memory write data, registered
//  mem_rdata  in   DATA_W  memory read data, valid in last access cycle
//  if_stall   out  1       if_req & ~if_ready
//  dm_stall   out  1       dm_req & ~dm_ready
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, cnt=0, starve=0. mem_cs, mem_we,
//    mem_addr and mem_wdata are 0. All ready signals are 0.
//  - FSM has three states: IDLE, IF_ACC, DM_ACC.
//  - IDLE: the arbiter samples requests at the clock edge.
//    - Only dm_req high -> DM_ACC. Only if_req high -> IF_ACC.
//    - Both high -> DM_ACC, unless starve==STARVE_LIMIT, then IF_ACC.
//    - On grant: latch addr, we (IF: 0) and wdata into the mem_* registers.
//      Set mem_cs=1 and cnt=WAIT_CYCLES.
//  - *_ACC: mem_* outputs hold stable. cnt decrements by 1 per cycle.
//    - When cnt==0, the granted ready is high combinationally and
//      *_rdata = mem_rdata.
//    - At that edge: state->IDLE, mem_cs=0, mem_we=0. mem_addr and
//      mem_wdata keep their last values.
//  - Latency: with the request seen in IDLE at cycle 0, ready is high in
//    cycle WAIT_CYCLES+1. After every access the arbiter spends one IDLE
//    turnaround cycle, so the ready cycle never causes a re-grant.
//  - Ready is never high for the non-granted requester.
//  - rdata outputs are 0 whenever their ready is low.
//  - Starvation counter:
//    - DM grant while if_req high -> starve = min(starve+1, STARVE_LIMIT).
//    - IF grant -> starve=0.
//    - IDLE with if_req low -> starve=0.
//  - Requests that drop before ready: the access still runs to completion
//    (writes are committed). Ready is still produced; the requester ignores it.
//  - Requests arriving mid-access wait. Stall stays high until their own
//    ready. No queueing beyond the one pending request per port.
//  - Reset mid-access aborts immediately. mem_cs drops asynchronously.
//    A partial write has undefined memory contents.
//  - WAIT_CYCLES=0: access lasts one cycle, and ready comes the cycle after
//    the grant edge.
// TESTING
//  1. WAIT=2, if_req=1 addr 0x10 alone, mem_rdata=0xA5 -> mem_cs in cycles
//     1-3, if_ready only in cycle 3, if_rdata=0xA5, if_stall high cycles 0-2.
//  2. Both requests in the same IDLE cycle -> DM_ACC first, dm_ready at
//     cycle 3, IDLE at 4, IF_ACC at 5-7, if_ready at 7.
//  3. dm write 0xDEAD_BEEF to 0x40 -> mem_we=1 with stable addr/wdata for
//     exactly 3 cycles. dm_ready=1, dm_rdata=0.
//  4. STARVE_LIMIT=4, dm_req held continuously, if_req held -> four DM
//     grants, then an IF grant, then starve=0.
//  5. rst low during cycle 2 of DM_ACC -> all outputs 0 immediately.
//     After release, a pending if_req is granted normally.
//  6. WAIT=0, alternating if/dm single requests -> one access every 2
//     cycles, with ready the cycle after each grant edge.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF-stage port, MEM-stage port, memory port and the
// status outputs that feed the pipeline freeze logic.
//  slave  : the arbiter's view (requests/read data in, ready/memory controls out)
//  master : the pipeline + memory view (the opposite directions)
interface mem_port_arbiter_if #(
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32
);
  logic             if_req;
  logic [AddrW-1:0] if_addr;
  logic             if_ready;
  logic [DataW-1:0] if_rdata;

  logic             dm_req;
  logic             dm_we;
  logic [AddrW-1:0] dm_addr;
  logic [DataW-1:0] dm_wdata;
  logic             dm_ready;
  logic [DataW-1:0] dm_rdata;

  logic             mem_cs;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic [DataW-1:0] mem_rdata;

  logic             if_stall;
  logic             dm_stall;
  logic             busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata, if_stall, dm_stall, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata, if_stall, dm_stall, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF stage (instruction read) and the MEM stage
// (data read/write). Each grant holds the memory for WaitCycles+1 cycles, followed by one
// IDLE turnaround cycle. Data wins ties unless IF has waited through StarveLimit data grants.
// Ports:
//  clk_i   : clock, rising edge
//  rst_ni  : asynchronous reset, active low
//  bus_io  : if_* / dm_* requester handshakes, registered mem_* controls, mem_rdata,
//            per-requester stalls and busy (see mem_port_arbiter_if)
module mem_port_arbiter #(
  parameter int unsigned AddrW       = 32,
  parameter int unsigned DataW       = 32,
  parameter int unsigned WaitCycles  = 2,   // 0..15
  parameter int unsigned StarveLimit = 4    // >= 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  mem_port_arbiter_if.slave     bus_io
);

  localparam int unsigned        StarveW   = $clog2(StarveLimit + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLimit);
  localparam logic [3:0]         CntInit   = 4'(WaitCycles);

  typedef enum logic [1:0] {StIdle, StIfAcc, StDmAcc} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               mem_cs_q, mem_cs_d;
  logic               mem_we_q, mem_we_d;
  logic [AddrW-1:0]   mem_addr_q, mem_addr_d;
  logic [DataW-1:0]   mem_wdata_q, mem_wdata_d;

  logic grant_dm, grant_if, last_cycle;

  // IF is forced ahead only when both request and it has been passed over StarveLimit times.
  assign grant_dm   = bus_io.dm_req & ~(bus_io.if_req & (starve_q == StarveMax));
  assign grant_if   = bus_io.if_req & ~grant_dm;
  assign last_cycle = (cnt_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    mem_cs_d    = mem_cs_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_dm) begin
          state_d     = StDmAcc;
          cnt_d       = CntInit;
          mem_cs_d    = 1'b1;
          mem_we_d    = bus_io.dm_we;
          mem_addr_d  = bus_io.dm_addr;
          mem_wdata_d = bus_io.dm_wdata;
          if (!bus_io.if_req) begin
            starve_d = '0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d    = StIfAcc;
          cnt_d      = CntInit;
          mem_cs_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus_io.if_addr;
          starve_d   = '0;
        end else begin
          starve_d = '0;
        end
      end
      StIfAcc, StDmAcc: begin
        if (last_cycle) begin
          // mem_addr/mem_wdata deliberately keep their last values.
          state_d  = StIdle;
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      starve_q    <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus_io.if_ready  = (state_q == StIfAcc) & last_cycle;
  assign bus_io.dm_ready  = (state_q == StDmAcc) & last_cycle;
  assign bus_io.if_rdata  = bus_io.if_ready ? bus_io.mem_rdata : '0;
  // mem_we_q still reflects the granted access in its ready cycle.
  assign bus_io.dm_rdata  = (bus_io.dm_ready & ~mem_we_q) ? bus_io.mem_rdata : '0;
  assign bus_io.mem_cs    = mem_cs_q;
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.if_stall  = bus_io.if_req & ~bus_io.if_ready;
  assign bus_io.dm_stall  = bus_io.dm_req & ~bus_io.dm_ready;
  assign bus_io.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AddrW(32), .DataW(32)) b  ();
  mem_port_arbiter_if #(.AddrW(32), .DataW(32)) b0 ();

  mem_port_arbiter #(.AddrW(32), .DataW(32), .WaitCycles(2), .StarveLimit(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(b)
  );

  mem_port_arbiter #(.AddrW(32), .DataW(32), .WaitCycles(0), .StarveLimit(4)) dut0 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(b0)
  );

  // Advance to just after the next active edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b.if_req = 0; b.if_addr = '0; b.dm_req = 0; b.dm_we = 0; b.dm_addr = '0;
    b.dm_wdata = '0; b.mem_rdata = '0;
    b0.if_req = 0; b0.if_addr = '0; b0.dm_req = 0; b0.dm_we = 0; b0.dm_addr = '0;
    b0.dm_wdata = '0; b0.mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    next_cycle(); next_cycle();
    total++;
    if ({b.mem_cs, b.mem_we, b.if_ready, b.dm_ready, b.busy} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000",
                      {b.mem_cs, b.mem_we, b.if_ready, b.dm_ready, b.busy});
    end
    total++;
    if (b.mem_addr !== 32'h0 || b.mem_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_data addr=%h wdata=%h want 0", b.mem_addr, b.mem_wdata);
    end
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_if_read();
    logic exp_cs, exp_rdy, exp_stall;
    b.if_req = 1; b.if_addr = 32'h10; b.mem_rdata = 32'hA5;
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) b.if_req = 0;
      #1;
      exp_cs = (c >= 1 && c <= 3); exp_rdy = (c == 3); exp_stall = (c <= 2);
      total++;
      if (b.mem_cs !== exp_cs || b.if_ready !== exp_rdy || b.if_stall !== exp_stall
          || b.dm_ready !== 1'b0) begin
        bad++; $display("FAIL if_read c=%0d cs/rdy/stall/dmrdy got=%b%b%b%b want=%b%b%b0", c,
                        b.mem_cs, b.if_ready, b.if_stall, b.dm_ready, exp_cs, exp_rdy, exp_stall);
      end
      total++;
      if (b.if_rdata !== (exp_rdy ? 32'hA5 : 32'h0)) begin
        bad++; $display("FAIL if_rdata c=%0d got=%h", c, b.if_rdata);
      end
      if (exp_cs) begin
        total++;
        if (b.mem_addr !== 32'h10 || b.mem_we !== 1'b0) begin
          bad++; $display("FAIL if_addr c=%0d got=%h we=%b want=10 0", c, b.mem_addr, b.mem_we);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_both_same_cycle();
    logic exp_dm, exp_if, exp_busy;
    logic [31:0] exp_addr;
    b.if_req = 1; b.if_addr = 32'h30; b.dm_req = 1; b.dm_we = 0; b.dm_addr = 32'h20;
    b.mem_rdata = 32'h77;
    for (int c = 0; c <= 8; c++) begin
      if (c == 4) b.dm_req = 0;
      if (c == 8) b.if_req = 0;
      #1;
      exp_dm = (c == 3); exp_if = (c == 7);
      exp_busy = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
      total++;
      if (b.dm_ready !== exp_dm || b.if_ready !== exp_if || b.busy !== exp_busy) begin
        bad++; $display("FAIL both c=%0d dm/if/busy got=%b%b%b want=%b%b%b", c,
                        b.dm_ready, b.if_ready, b.busy, exp_dm, exp_if, exp_busy);
      end
      if (exp_busy) begin
        exp_addr = (c <= 3) ? 32'h20 : 32'h30;
        total++;
        if (b.mem_addr !== exp_addr) begin
          bad++; $display("FAIL both_addr c=%0d got=%h want=%h", c, b.mem_addr, exp_addr);
        end
      end
      if (exp_dm) begin
        total++;
        if (b.dm_rdata !== 32'h77) begin
          bad++; $display("FAIL both_dm_rdata got=%h want=77", b.dm_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_write();
    logic exp_we, exp_rdy;
    b.dm_req = 1; b.dm_we = 1; b.dm_addr = 32'h40; b.dm_wdata = 32'hDEAD_BEEF;
    b.mem_rdata = 32'h55;
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) begin b.dm_req = 0; b.dm_we = 0; end
      #1;
      exp_we = (c >= 1 && c <= 3); exp_rdy = (c == 3);
      total++;
      if (b.mem_we !== exp_we || b.mem_cs !== exp_we || b.dm_ready !== exp_rdy) begin
        bad++; $display("FAIL write c=%0d we/cs/rdy got=%b%b%b want=%b%b%b", c,
                        b.mem_we, b.mem_cs, b.dm_ready, exp_we, exp_we, exp_rdy);
      end
      if (c >= 1) begin
        total++;
        if (b.mem_addr !== 32'h40 || b.mem_wdata !== 32'hDEAD_BEEF) begin
          bad++; $display("FAIL write_data c=%0d addr=%h wdata=%h want 40 deadbeef", c,
                          b.mem_addr, b.mem_wdata);
        end
      end
      total++;
      if (b.dm_rdata !== 32'h0) begin
        bad++; $display("FAIL write_rdata c=%0d got=%h want=0", c, b.dm_rdata);
      end
      next_cycle();
    end
  endtask

  task automatic test_starvation();
    int  k;
    logic is_if, exp_dm, exp_if;
    b.if_req = 1; b.if_addr = 32'h100; b.dm_req = 1; b.dm_we = 0; b.dm_addr = 32'h200;
    for (int c = 0; c <= 40; c++) begin
      if (c == 40) begin b.if_req = 0; b.dm_req = 0; end
      #1;
      // Four-cycle slots: four DM grants, then IF, then starve counts afresh.
      k = c / 4;
      is_if = (k == 4) || (k == 9);
      exp_dm = (c % 4 == 3) && !is_if && (c < 40);
      exp_if = (c % 4 == 3) && is_if;
      total++;
      if (b.dm_ready !== exp_dm || b.if_ready !== exp_if) begin
        bad++; $display("FAIL starve c=%0d dm/if got=%b%b want=%b%b", c,
                        b.dm_ready, b.if_ready, exp_dm, exp_if);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_access();
    b.dm_req = 1; b.dm_we = 1; b.dm_addr = 32'h80; b.dm_wdata = 32'h1234_5678;
    b.if_req = 1; b.if_addr = 32'h300; b.mem_rdata = 32'h99;
    next_cycle();  // cycle 1: first DM_ACC cycle
    total++;
    if (b.mem_cs !== 1'b1 || b.mem_we !== 1'b1) begin
      bad++; $display("FAIL midrst_pre cs=%b we=%b want=11", b.mem_cs, b.mem_we);
    end
    next_cycle();  // cycle 2
    b.dm_req = 0; b.dm_we = 0;
    rst_n = 0;
    #1;
    total++;
    if ({b.mem_cs, b.mem_we, b.if_ready, b.dm_ready, b.busy} !== 5'b0
        || b.mem_addr !== 32'h0 || b.mem_wdata !== 32'h0) begin
      bad++; $display("FAIL midrst ctrl=%b addr=%h wdata=%h want all 0",
                      {b.mem_cs, b.mem_we, b.if_ready, b.dm_ready, b.busy},
                      b.mem_addr, b.mem_wdata);
    end
    next_cycle();
    rst_n = 1;
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) b.if_req = 0;
      #1;
      total++;
      if (b.if_ready !== (c == 3) || b.mem_cs !== (c >= 1 && c <= 3) || b.dm_ready !== 1'b0)
      begin
        bad++; $display("FAIL midrst_after c=%0d rdy=%b cs=%b dm=%b", c,
                        b.if_ready, b.mem_cs, b.dm_ready);
      end
      if (c == 3) begin
        total++;
        if (b.mem_addr !== 32'h300 || b.if_rdata !== 32'h99) begin
          bad++; $display("FAIL midrst_if addr=%h rdata=%h want 300 99", b.mem_addr, b.if_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_wait0_alternate();
    int  kind;
    logic odd, exp_if, exp_dm;
    b0.if_addr = 32'h500; b0.dm_addr = 32'h600; b0.dm_we = 0; b0.mem_rdata = 32'h3C;
    for (int c = 0; c <= 10; c++) begin
      odd = (c % 2 == 1);
      kind = (c / 2) % 2;
      if (!odd) begin
        b0.if_req = (kind == 0) && (c < 10);
        b0.dm_req = (kind == 1) && (c < 10);
      end
      #1;
      exp_if = odd && (kind == 0);
      exp_dm = odd && (kind == 1);
      total++;
      if (b0.mem_cs !== odd || b0.if_ready !== exp_if || b0.dm_ready !== exp_dm) begin
        bad++; $display("FAIL wait0 c=%0d cs/if/dm got=%b%b%b want=%b%b%b", c,
                        b0.mem_cs, b0.if_ready, b0.dm_ready, odd, exp_if, exp_dm);
      end
      if (odd) begin
        total++;
        if (b0.mem_addr !== (kind == 0 ? 32'h500 : 32'h600)) begin
          bad++; $display("FAIL wait0_addr c=%0d got=%h", c, b0.mem_addr);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_if_read();
    test_both_same_cycle();
    test_write();
    test_starvation();
    test_reset_mid_access();
    test_wait0_alternate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
